// File: rtl/fifo_wr_arbiter_if.sv
// Requester burst handshake and FIFO write port bundled for the write-side arbiter.
// master = requesters/FIFO model side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_full;
    logic [6:0]                     fifo_counter;
    logic                           fifo_wr_en;
    logic [DATA_W-1:0]              fifo_din;
    logic [NUM_REQ-1:0]             grant;
    logic                           busy;

    modport master (
        output req_valid, req_last, req_data, fifo_full, fifo_counter,
        input  req_ready, fifo_wr_en, fifo_din, grant, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full, fifo_counter,
        output req_ready, fifo_wr_en, fifo_din, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_AFULL_EN to also stall on the almost-full occupancy threshold.

module fifo_wr_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              gnt,
    input  logic              vld,
    input  logic              stall,
    input  logic [DATA_W-1:0] data,
    output logic              rdy,
    output logic              wr,
    output logic [DATA_W-1:0] din
);
    assign rdy = gnt & ~stall;
    assign wr  = vld & rdy;
    assign din = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                         state;
    logic [NUM_REQ-1:0]             grant;
    logic                           busy;
    logic [BEAT_W-1:0]              beat_cnt;
    logic [IDLE_W-1:0]              idle_cnt;
    logic [IDX_W-1:0]               last_grant;

    logic                           stall;
    logic [IDX_W-1:0]               sel;
    logic [IDX_W-1:0]               cand;
    logic                           any_valid;
    logic                           g_valid;
    logic                           g_last;
    logic                           accept;
    logic [NUM_REQ-1:0]             lane_rdy;
    logic [NUM_REQ-1:0]             lane_wr;
    logic [NUM_REQ-1:0][DATA_W-1:0] lane_din;
    logic [DATA_W-1:0]              din;

`ifdef FIFO_WR_ARB_AFULL_EN
    assign stall = bus.fifo_full | (bus.fifo_counter >= 7'(FIFO_DEPTH - AFULL_MARGIN));
`else
    logic unused_afull;
    assign unused_afull = ^{bus.fifo_counter, 7'(FIFO_DEPTH - AFULL_MARGIN)};
    assign stall = bus.fifo_full;
`endif

    // Lanes see grant directly, so nothing is ready or steered while IDLE (grant == 0).
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .gnt   (grant[i]),
            .vld   (bus.req_valid[i]),
            .stall (stall),
            .data  (bus.req_data[i]),
            .rdy   (lane_rdy[i]),
            .wr    (lane_wr[i]),
            .din   (lane_din[i])
        );
    end

    always_comb begin
        din = '0;
        for (int i = 0; i < NUM_REQ; i++) din = din | lane_din[i];
    end

    assign bus.req_ready  = lane_rdy;
    assign bus.fifo_wr_en = |lane_wr;
    assign bus.fifo_din   = din;
    assign bus.grant      = grant;
    assign bus.busy       = busy;

    // last_grant doubles as the granted index while in BURST.
    assign g_valid   = bus.req_valid[last_grant];
    assign g_last    = bus.req_last[last_grant];
    assign accept    = bus.fifo_wr_en;
    assign any_valid = |bus.req_valid;

    // Scan from the far end back toward last_grant+1 so the nearest valid index wins.
    always_comb begin
        sel  = last_grant;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (bus.req_valid[cand]) sel = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state      <= BURST;
                        grant      <= NUM_REQ'(1) << sel;
                        busy       <= 1'b1;
                        last_grant <= sel;
                        beat_cnt   <= '0;
                        idle_cnt   <= '0;
                    end
                end
                BURST: begin
                    if ((accept && (g_last || beat_cnt == BEAT_W'(MAX_BURST - 1))) ||
                        (!g_valid && idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1))) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        if (accept) beat_cnt <= beat_cnt + BEAT_W'(1);
                        // A stalled but valid beat still clears the idle count.
                        idle_cnt <= g_valid ? '0 : idle_cnt + IDLE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a
// queue-based model of requesters, round-robin order and burst lengths.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int IT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) arb_if ();

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT),
        .FIFO_DEPTH(64), .AFULL_MARGIN(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (arb_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester beat queues: data, last flag, head and tail.
    logic [DW-1:0] qd   [N][256];
    logic          qlst [N][256];
    int            qh   [N];
    int            qt   [N];
    logic [N-1:0]  hold_off;

    // Observations from the most recent cycle and a grant/write log.
    logic [N-1:0]  o_grant, o_ready, o_valid, p_grant;
    logic          o_wr, o_busy, o_full;
    logic [DW-1:0] o_din;
    int            gseq [64];
    int            wcnt [64];
    logic [DW-1:0] wlog [256];
    int            ng, nw;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] x;
        x = '0;
        x = x | (N'(1) << i);
        return x;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g == onehot(i)) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = v >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int burst_len(input int r, input int h);
        int n;
        n = 0;
        for (int j = h; j < qt[r]; j++) begin
            n++;
            if (qlst[r][j] || n == MB) return n;
        end
        return n;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (qh[i] != qt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        qd[r][qt[r]]   = d;
        qlst[r][qt[r]] = l;
        qt[r]++;
    endtask

    task automatic drive();
        logic [N-1:0]         v, l;
        logic [N-1:0][DW-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (qh[i] != qt[i]) begin
                v[i] = !hold_off[i];
                l[i] = qlst[i][qh[i]];
                d[i] = qd[i][qh[i]];
            end
        end
        arb_if.req_valid = v;
        arb_if.req_last  = l;
        arb_if.req_data  = d;
    endtask

    // One clock: drive, sample at negedge, pop accepted beats after the edge.
    task automatic step();
        drive();
        @(negedge clk);
        o_grant = arb_if.grant;
        o_ready = arb_if.req_ready;
        o_wr    = arb_if.fifo_wr_en;
        o_din   = arb_if.fifo_din;
        o_busy  = arb_if.busy;
        o_valid = arb_if.req_valid;
        o_full  = arb_if.fifo_full;
        if (o_grant != '0 && p_grant == '0 && ng < 64) begin
            gseq[ng] = idx_of(o_grant);
            wcnt[ng] = 0;
            ng++;
        end
        if (o_wr && nw < 256) begin
            wlog[nw] = o_din;
            nw++;
            if (ng > 0) wcnt[ng-1]++;
        end
        p_grant = o_grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (o_valid[i] && o_ready[i]) qh[i]++;
    endtask

    task automatic drain(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = all_empty() && o_grant == '0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: did not finish within %0d cycles", name, budget);
        end
    endtask

    task automatic reset_dut();
        arb_if.fifo_full    = 1'b0;
        arb_if.fifo_counter = '0;
        hold_off            = '0;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
        ng = 0; nw = 0; p_grant = '0;
        drive();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arb_if.req_valid = '1;
        arb_if.req_last  = '0;
        arb_if.req_data  = {N{8'hA5}};
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks += 5;
        if (arb_if.grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 0", arb_if.grant); end
        if (arb_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", arb_if.busy); end
        if (arb_if.req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", arb_if.req_ready); end
        if (arb_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", arb_if.fifo_wr_en); end
        if (arb_if.fifo_din !== '0) begin errors++; $display("FAIL reset_din got %h want 0", arb_if.fifo_din); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int j = 0; j < 4; j++) push(1, 8'($urandom), j == 3);
        step();
        step();
        drive();
        #1;
        checks += 5;
        if (arb_if.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b want 1", arb_if.fifo_wr_en); end
        #1 rst_n = 1'b0;
        #1;
        if (arb_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got %b want 0", arb_if.fifo_wr_en); end
        if (arb_if.grant !== '0) begin errors++; $display("FAIL mid_rst_grant got %b want 0", arb_if.grant); end
        if (arb_if.req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", arb_if.req_ready); end
        if (arb_if.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", arb_if.busy); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        reset_dut();
        for (int j = 0; j < 3; j++) push(0, exp_d[j], j == 2);
        step();
        checks += 2;
        if (o_grant !== '0) begin errors++; $display("FAIL single_arb_grant got %b want 0", o_grant); end
        if (o_wr !== 1'b0) begin errors++; $display("FAIL single_arb_wr got %b want 0", o_wr); end
        for (int j = 0; j < 3; j++) begin
            step();
            checks += 3;
            if (o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant[%0d] got %b want 0001", j, o_grant); end
            if (o_wr !== 1'b1) begin errors++; $display("FAIL single_wr[%0d] got %b want 1", j, o_wr); end
            if (o_din !== exp_d[j]) begin errors++; $display("FAIL single_din[%0d] got %h want %h", j, o_din, exp_d[j]); end
        end
        step();
        checks += 3;
        if (o_grant !== '0) begin errors++; $display("FAIL single_release got %b want 0", o_grant); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", o_busy); end
        if (o_wr !== 1'b0) begin errors++; $display("FAIL single_after_wr got %b want 0", o_wr); end
    endtask

    task automatic test_round_robin();
        int r, j;
        reset_dut();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) push(i, 8'($urandom), 1'b1);
        for (int k = 0; k < 4 * N; k++) begin
            step();
            checks++;
            if (k % 2 == 0) begin
                if (o_grant !== '0) begin errors++; $display("FAIL rr_idle[%0d] got %b want 0", k, o_grant); end
            end else begin
                r = (k / 2) % N;
                j = (k / 2) / N;
                if (o_grant !== onehot(r)) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, o_grant, onehot(r)); end
                checks++;
                if (o_din !== qd[r][j]) begin errors++; $display("FAIL rr_din[%0d] got %h want %h", k, o_din, qd[r][j]); end
            end
        end
    endtask

    task automatic test_max_burst();
        int exp_g [5];
        int exp_w [5];
        exp_g = '{2, 3, 0, 1, 2};
        exp_w = '{16, 1, 1, 1, 4};
        reset_dut();
        for (int j = 0; j < 20; j++) push(2, 8'($urandom), j == 19);
        push(0, 8'($urandom), 1'b1);
        push(1, 8'($urandom), 1'b1);
        push(3, 8'($urandom), 1'b1);
        hold_off = 4'b1011;
        step();
        hold_off = '0;
        drain(200, "maxb");
        checks++;
        if (ng !== 5) begin errors++; $display("FAIL maxb_grants got %0d want 5", ng); end
        for (int i = 0; i < 5 && i < ng; i++) begin
            checks += 2;
            if (gseq[i] !== exp_g[i]) begin errors++; $display("FAIL maxb_order[%0d] got %0d want %0d", i, gseq[i], exp_g[i]); end
            if (wcnt[i] !== exp_w[i]) begin errors++; $display("FAIL maxb_beats[%0d] got %0d want %0d", i, wcnt[i], exp_w[i]); end
        end
        checks += 2;
        if (wlog[15] !== qd[2][15]) begin errors++; $display("FAIL maxb_d15 got %h want %h", wlog[15], qd[2][15]); end
        if (wlog[19] !== qd[2][16]) begin errors++; $display("FAIL maxb_d16 got %h want %h", wlog[19], qd[2][16]); end
    endtask

    task automatic test_full_stall();
        reset_dut();
        for (int j = 0; j < 6; j++) push(1, 8'($urandom), j == 5);
        step();
        step();
        step();
        arb_if.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks += 3;
            if (o_wr !== 1'b0) begin errors++; $display("FAIL stall_wr[%0d] got %b want 0", c, o_wr); end
            if (o_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", c, o_ready); end
            if (o_grant !== 4'b0010) begin errors++; $display("FAIL stall_grant[%0d] got %b want 0010", c, o_grant); end
        end
        arb_if.fifo_full = 1'b0;
        drain(50, "stall");
        checks += 2;
        if (nw !== 6) begin errors++; $display("FAIL stall_writes got %0d want 6", nw); end
        if (ng !== 1) begin errors++; $display("FAIL stall_grants got %0d want 1", ng); end
        for (int j = 0; j < 6 && j < nw; j++) begin
            checks++;
            if (wlog[j] !== qd[1][j]) begin errors++; $display("FAIL stall_d[%0d] got %h want %h", j, wlog[j], qd[1][j]); end
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        push(0, 8'($urandom), 1'b1);
        push(1, 8'($urandom), 1'b1);
        push(3, 8'($urandom), 1'b1);
        hold_off = 4'b1010;
        step();
        hold_off = 4'b0001;
        for (int c = 0; c < IT; c++) begin
            step();
            checks += 2;
            if (o_grant !== 4'b0001) begin errors++; $display("FAIL tmo_grant[%0d] got %b want 0001", c, o_grant); end
            if (o_wr !== 1'b0) begin errors++; $display("FAIL tmo_wr[%0d] got %b want 0", c, o_wr); end
        end
        hold_off = '0;
        step();
        checks += 2;
        if (o_grant !== '0) begin errors++; $display("FAIL tmo_release got %b want 0", o_grant); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", o_busy); end
        step();
        checks += 2;
        if (o_grant !== 4'b0010) begin errors++; $display("FAIL tmo_next got %b want 0010", o_grant); end
        if (o_din !== qd[1][0]) begin errors++; $display("FAIL tmo_din got %h want %h", o_din, qd[1][0]); end
    endtask

    task automatic test_afull();
        reset_dut();
        for (int j = 0; j < 4; j++) push(0, 8'($urandom), j == 3);
`ifdef FIFO_WR_ARB_AFULL_EN
        arb_if.fifo_counter = 7'd59;
        step();
        step();
        checks += 4;
        if (o_ready !== 4'b0001) begin errors++; $display("FAIL afull59_ready got %b want 0001", o_ready); end
        if (o_wr !== 1'b1) begin errors++; $display("FAIL afull59_wr got %b want 1", o_wr); end
        arb_if.fifo_counter = 7'd60;
        step();
        if (o_ready !== '0) begin errors++; $display("FAIL afull60_ready got %b want 0", o_ready); end
        if (o_wr !== 1'b0) begin errors++; $display("FAIL afull60_wr got %b want 0", o_wr); end
`else
        arb_if.fifo_counter = 7'd60;
        step();
        step();
        checks += 4;
        if (o_ready !== 4'b0001) begin errors++; $display("FAIL noafull60_ready got %b want 0001", o_ready); end
        if (o_wr !== 1'b1) begin errors++; $display("FAIL noafull60_wr got %b want 1", o_wr); end
        arb_if.fifo_counter = 7'd63;
        step();
        if (o_ready !== 4'b0001) begin errors++; $display("FAIL noafull63_ready got %b want 0001", o_ready); end
        if (o_wr !== 1'b1) begin errors++; $display("FAIL noafull63_wr got %b want 1", o_wr); end
`endif
        arb_if.fifo_counter = '0;
        drain(50, "afull");
        checks++;
        if (nw !== 4) begin errors++; $display("FAIL afull_writes got %0d want 4", nw); end
    endtask

    task automatic test_random();
        int           hs [N];
        int           m_last, g, bl, wc, len;
        logic [N-1:0] rp_g, rp_v, exp_g, exp_r;
        bit           done;
        reset_dut();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 3; b++) begin
                len = $urandom_range(1, 20);
                for (int j = 0; j < len; j++) push(i, 8'($urandom), j == len - 1);
            end
        m_last = N - 1; rp_g = '0; rp_v = '0; bl = 0; wc = 0; g = 0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if ($urandom_range(0, 9) == 0) arb_if.fifo_full = ~arb_if.fifo_full;
            for (int i = 0; i < N; i++) hs[i] = qh[i];
            step();
            checks += 3;
            if (o_wr && o_full) begin errors++; $display("FAIL rnd_wr_full cycle %0d got wr=1 want 0", c); end
            exp_r = o_full ? '0 : o_grant;
            if (o_ready !== exp_r) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, o_ready, exp_r); end
            if (o_busy !== (o_grant != '0)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, o_busy, o_grant != '0); end
            checks++;
            if (rp_g == '0) begin
                exp_g = (rp_v == '0) ? '0 : onehot(rr_pick(rp_v, m_last));
                if (o_grant !== exp_g) begin errors++; $display("FAIL rnd_grant cycle %0d got %b want %b", c, o_grant, exp_g); end
                if (o_grant != '0) begin
                    g = idx_of(o_grant);
                    m_last = g;
                    bl = burst_len(g, hs[g]);
                    wc = 0;
                end
            end else if (o_grant == '0) begin
                if (wc !== bl) begin errors++; $display("FAIL rnd_burst_len cycle %0d got %0d want %0d", c, wc, bl); end
            end else begin
                if (o_grant !== rp_g) begin errors++; $display("FAIL rnd_grant_hold cycle %0d got %b want %b", c, o_grant, rp_g); end
            end
            if (o_wr && o_grant != '0) begin
                checks++;
                if (o_din !== qd[g][hs[g]]) begin errors++; $display("FAIL rnd_din cycle %0d got %h want %h", c, o_din, qd[g][hs[g]]); end
                wc++;
            end
            rp_g = o_grant;
            rp_v = o_valid;
            done = all_empty() && o_grant == '0;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL rnd_drain: did not finish within 3000 cycles"); end
    endtask

    initial begin
        arb_if.req_valid    = '0;
        arb_if.req_last     = '0;
        arb_if.req_data     = '0;
        arb_if.fifo_full    = 1'b0;
        arb_if.fifo_counter = '0;
        hold_off = '0;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
        test_reset();
        test_reset_mid();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_timeout();
        test_afull();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 64-entry, 8-bit FIFO among NUM_REQ requesters.
- Each requester uses a valid/ready/last burst handshake.
- The arbiter grants one requester per burst and steers its data onto the FIFO write port.
- It back-pressures the granted requester whenever the FIFO is full.
- Sits on the write side of the FIFO, in the same clock domain as the FIFO write clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per requester; matches FIFO width
MAX_BURST, 16, maximum beats per grant before forced release (1..64)
IDLE_TIMEOUT, 8, consecutive cycles with granted valid low before forced release (1..255)
FIFO_DEPTH, 64, FIFO depth, used for the almost-full threshold
AFULL_MARGIN, 4, free-entry margin for the almost-full stall

Ports:
clk  input  1  single clock, same as FIFO write clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_last  input  NUM_REQ  per-requester last beat of burst, qualified by valid
req_data  input  NUM_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester ready; at most one bit high
fifo_full  input  1  FIFO full flag
fifo_counter  input  7  FIFO occupancy 0..64
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DATA_W  FIFO write data
grant  output  NUM_REQ  registered one-hot grant; all zero in IDLE
busy  output  1  high in BURST state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, busy=0, beat counter=0, idle counter=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
- Combinational outputs at reset: req_ready=0, fifo_wr_en=0, fifo_din=0.
- States are IDLE and BURST.
- IDLE: if any req_valid is high, select the first valid index scanning from last_grant+1 upward, mod NUM_REQ.
  - Next edge: grant=onehot(sel), last_grant=sel, state=BURST, counters cleared.
  - One-cycle arbitration latency: no beat is accepted in IDLE.
- BURST, with g = granted index:
  - req_ready[g] = !stall; all other ready bits are 0.
  - stall = fifo_full (see optional feature).
  - fifo_wr_en = req_valid[g] & req_ready[g], combinational.
  - fifo_din = req_data[g] when granted, else 0.
- An accepted beat increments the beat counter.
- Release on an accepted beat if req_last[g]=1 or beat count reaches MAX_BURST (i.e. the MAX_BURST-th beat).
  - Release means: next edge state=IDLE, grant=0, busy=0.
- Idle counter:
  - Increments each BURST cycle with req_valid[g]=0.
  - Clears on any cycle where req_valid[g]=1, including stalled cycles.
  - Reaching IDLE_TIMEOUT releases the grant with no write.
- Stall does not count toward the timeout; beats are held indefinitely while the FIFO is full.
- req_last with a stalled beat has no effect until that beat is accepted.
- Non-granted requesters are ignored during BURST and must hold valid and data.
- Back-to-back bursts always pass through one IDLE cycle.
- Round-robin rotation is based on last_grant only; a timeout release still advances priority.
- Reset mid-burst: immediate return to IDLE. The in-flight beat is not written, because fifo_wr_en goes low combinationally.
- fifo_wr_en is never high when fifo_full=1.

Optional Feature:
- Macro: FIFO_WR_ARB_AFULL_EN.
- Defined: stall = fifo_full | (fifo_counter >= FIFO_DEPTH - AFULL_MARGIN); with defaults, ready drops at occupancy 60.
- Undefined: stall = fifo_full only; fifo_counter is present but ignored.

Test Plan:
- Reset, then req_valid=4'b0001, data 0x11,0x22,0x33 with last on 0x33 -> grant=0001 one cycle after valid; three FIFO writes 0x11,0x22,0x33; IDLE on the next edge.
- req_valid=4'b1111 held, each burst one beat with last -> grants in order 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
- Requester 2 streams 20 beats, last never set, MAX_BURST=16 -> exactly 16 writes, release; requester 2 re-granted only after the other valid requesters are served.
- fifo_full forced high for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 5 cycles; no timeout; the burst resumes with the held beat written once.
- Granted requester drops valid for 8 cycles (IDLE_TIMEOUT=8) -> grant released after the 8th cycle, no writes; the next valid requester in round-robin order is granted.
- With FIFO_WR_ARB_AFULL_EN defined: fifo_counter=59 gives req_ready=1; fifo_counter=60 gives req_ready=0 and fifo_wr_en=0.
- Without the macro, fifo_counter=60 and fifo_full=0 -> ready stays 1.
